tb_run_controller: RTL

- Synthesizable run-control block that replaces ad-hoc testbench control loops.
- Sequences DUT reset, monitors N commit channels for halt, watches K error sources with a drain window, and enforces a cycle or stall timeout.
- Drives a sticky finish flag, a termination code, and run statistics.
- Sits beside the monitor in the top-level bench; the bench calls $finish on finish.

---
 rtl/tb_run_controller_if.sv | 26 ++
 rtl/tb_run_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tb_run_controller_if.sv
// Run-control bundle: DUT-side observation inputs and run-status outputs.
// The bench side (master) drives commit/halt/error, the controller (slave) reports run state.
interface tb_run_controller_if #(
    parameter int CHANNELS = 8,
    parameter int ERR_SRCS = 3
);
    logic [CHANNELS-1:0] commit_valid;
    logic [CHANNELS-1:0] halt;
    logic [ERR_SRCS-1:0] err;
    logic                dut_rst;
    logic                finish;
    logic [1:0]          finish_code;
    logic [ERR_SRCS-1:0] err_src;
    logic [63:0]         cycle_count;
    logic [63:0]         commit_count;

    modport master (
        output commit_valid, halt, err,
        input  dut_rst, finish, finish_code, err_src, cycle_count, commit_count
    );

    modport slave (
        input  commit_valid, halt, err,
        output dut_rst, finish, finish_code, err_src, cycle_count, commit_count
    );
endinterface

// File: rtl/tb_run_controller.sv
// Run controller: sequences DUT reset, ends the run on halt, error (after a drain window) or timeout.
// Define TB_RUN_CTRL_STALL_WATCHDOG_EN to turn the absolute timeout into a no-commit watchdog.
module tb_run_controller #(
    parameter int CHANNELS         = 8,
    parameter int ERR_SRCS         = 3,
    parameter int RESET_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES   = 100000,
    parameter int ERR_DRAIN_CYCLES = 5
) (
    input logic             clk,
    input logic             rst,
    tb_run_controller_if.slave bus
);

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        RUN       = 2'd1,
        DRAIN     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int CW = $clog2(CHANNELS + 1);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int DW = (ERR_DRAIN_CYCLES > 1) ? $clog2(ERR_DRAIN_CYCLES + 1) : 1;

    localparam logic [RW-1:0] RSEQ_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DRN_LOAD  = DW'(ERR_DRAIN_CYCLES);
    localparam bit            TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_t              state, state_n;
    logic [RW-1:0]       rseq_cnt, rseq_n;
    logic [TW-1:0]       tmo_cnt, tmo_n;
    logic [DW-1:0]       drn_cnt, drn_n;
    logic                dut_rst_q, dut_rst_n;
    logic                finish_q, finish_n;
    logic [1:0]          code_q, code_n;
    logic [ERR_SRCS-1:0] err_src_q, err_src_n;
    logic [63:0]         cyc_q, cyc_n;
    logic [63:0]         com_q, com_n;

    logic [CW-1:0]       commit_pop;
    logic                err_any;
    logic                halt_hit;
    logic                tmo_reload;
    logic                tmo_hit;

    always_comb begin
        commit_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            commit_pop = commit_pop + CW'(bus.commit_valid[i]);
        end
    end

    assign err_any  = |bus.err;
    assign halt_hit = |(bus.halt & bus.commit_valid);

`ifdef TB_RUN_CTRL_STALL_WATCHDOG_EN
    // Any retirement counts as progress and rearms the watchdog.
    assign tmo_reload = |bus.commit_valid;
`else
    assign tmo_reload = 1'b0;
`endif

    assign tmo_hit = TMO_EN && !tmo_reload && (tmo_cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_SEQ;
            rseq_cnt  <= '0;
            tmo_cnt   <= TMO_LOAD;
            drn_cnt   <= DRN_LOAD;
            dut_rst_q <= 1'b1;
            finish_q  <= 1'b0;
            code_q    <= 2'd0;
            err_src_q <= '0;
            cyc_q     <= '0;
            com_q     <= '0;
        end else begin
            state     <= state_n;
            rseq_cnt  <= rseq_n;
            tmo_cnt   <= tmo_n;
            drn_cnt   <= drn_n;
            dut_rst_q <= dut_rst_n;
            finish_q  <= finish_n;
            code_q    <= code_n;
            err_src_q <= err_src_n;
            cyc_q     <= cyc_n;
            com_q     <= com_n;
        end
    end

    always_comb begin
        state_n   = state;
        rseq_n    = rseq_cnt;
        tmo_n     = tmo_cnt;
        drn_n     = drn_cnt;
        dut_rst_n = dut_rst_q;
        finish_n  = finish_q;
        code_n    = code_q;
        err_src_n = err_src_q;
        cyc_n     = cyc_q;
        com_n     = com_q;

        case (state)
            RESET_SEQ: begin
                rseq_n = rseq_cnt + 1'b1;
                if (rseq_cnt == RSEQ_LAST) begin
                    state_n   = RUN;
                    dut_rst_n = 1'b0;
                end
            end

            RUN: begin
                cyc_n = cyc_q + 64'd1;
                com_n = com_q + 64'(commit_pop);
                if (TMO_EN) begin
                    tmo_n = tmo_reload ? TMO_LOAD : tmo_cnt - 1'b1;
                end
                // Error outranks halt, which outranks timeout.
                if (err_any) begin
                    err_src_n = bus.err;
                    code_n    = 2'd2;
                    drn_n     = DRN_LOAD;
                    state_n   = DRAIN;
                end else if (halt_hit) begin
                    code_n   = 2'd1;
                    finish_n = 1'b1;
                    state_n  = DONE;
                end else if (tmo_hit) begin
                    code_n   = 2'd3;
                    finish_n = 1'b1;
                    state_n  = DONE;
                end
            end

            DRAIN: begin
                cyc_n = cyc_q + 64'd1;
                com_n = com_q + 64'(commit_pop);
                // A zero-length window still spends one DRAIN cycle.
                if (drn_cnt <= DW'(1)) begin
                    finish_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    drn_n = drn_cnt - 1'b1;
                end
            end

            DONE: begin
                state_n = DONE;
            end

            default: begin
                state_n = RESET_SEQ;
            end
        endcase
    end

    assign bus.dut_rst      = dut_rst_q;
    assign bus.finish       = finish_q;
    assign bus.finish_code  = code_q;
    assign bus.err_src      = err_src_q;
    assign bus.cycle_count  = cyc_q;
    assign bus.commit_count = com_q;

endmodule
